// File: rtl/wc25_pkg.sv
// Shared types and constants for the Winograd F(2,5) stream controller.
// The window is six samples wide; each window advances by two and yields two results.
package wc25_pkg;

    typedef enum logic [1:0] {
        StFill,
        StWait,
        StEmit
    } state_t;

    localparam int unsigned WIN    = 6;
    localparam int unsigned NOUT   = 2;
    localparam int unsigned STRIDE = 2;

    // Bit offset of window slot `slot` (0 = oldest, packed in the MSBs).
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned dw);
        return (WIN - 1 - slot) * dw;
    endfunction

endpackage

// File: rtl/wc25_stream_ctrl.sv
// Builds stride-2 six-sample windows from a framed stream, holds each for the WC core
// latency, then captures the result pair and hands it to the sink.
module wc25_stream_ctrl
    import wc25_pkg::*;
#(
    parameter int unsigned DW     = 10,
    parameter int unsigned WC_LAT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_last,
    output logic [WIN*DW-1:0]    wc_d,
    input  logic [NOUT*DW-1:0]   wc_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NOUT*DW-1:0]   out_data,
    output logic                 out_last,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned LatW = (WC_LAT > 1) ? $clog2(WC_LAT) : 1;
    localparam int unsigned CntW = $clog2(WIN + 1);
    localparam logic [LatW-1:0] LatMax   = LatW'(WC_LAT - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(WIN);
    localparam logic [CntW-1:0] CntKeep  = CntW'(WIN - STRIDE);

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                  last_seen_q, last_seen_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic [WIN*DW-1:0]     win_q, win_d;
    logic [NOUT*DW-1:0]    out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  frame_err_q, frame_err_d;

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        lat_d       = lat_q;
        win_d       = win_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            StFill: begin
                if (in_valid) begin
                    win_d = {win_q[(WIN-1)*DW-1:0], in_data};
                    if (cnt_inc == CntFull) begin
                        state_d     = StWait;
                        cnt_d       = cnt_inc;
                        lat_d       = '0;
                        last_seen_d = in_last;
                    end else if (in_last) begin
                        // Frame ended before the window filled: drop the partial window.
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                        last_seen_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StWait: begin
                if (lat_q == LatMax) begin
                    out_data_d  = wc_z;
                    out_last_d  = last_seen_q;
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StEmit: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StFill;
                    if (out_last_q) begin
                        cnt_d       = '0;
                        last_seen_d = 1'b0;
                    end else begin
                        // Two oldest samples are retired by the next two shifts.
                        cnt_d = CntKeep;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            lat_q       <= '0;
            win_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            lat_q       <= lat_d;
            win_q       <= win_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready  = (state_q == StFill);
    assign busy      = (state_q != StFill) || (cnt_q != '0);
    assign wc_d      = win_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;

endmodule
